// File: rtl/fpu_dispatch_pkg.sv
// Shared types and defaults for the fpu_core request dispatcher.
package fpu_dispatch_pkg;

  localparam int unsigned FPU_32               = 32;
  localparam int unsigned FPU_DISPATCH_DEPTH   = 4;
  localparam int unsigned FPU_DISPATCH_TIMEOUT = 64;
  localparam int unsigned OpW                  = 2;

  typedef enum logic [OpW-1:0] {
    OpAdd = 2'd0,
    OpSub = 2'd1,
    OpMul = 2'd2
  } operation_e;

  typedef enum logic [1:0] {
    DIdle,
    DIssue,
    DWait,
    DResp
  } dispatch_state_e;

  // Queue entry layout: {op, a, b, tag}
  function automatic int unsigned fifo_entry_w(input int unsigned width, input int unsigned tag_w);
    return OpW + 2 * width + tag_w;
  endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// In-order request queue: registered storage and pointers, count/full/empty from registered state.
module fpu_req_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fpu_dispatch.sv
// Queues tagged FP requests and runs them one at a time through fpu_core's start/busy port.
// Define FPU_DISPATCH_TIMEOUT_EN to add a watchdog that aborts a stuck D_WAIT with rsp_err.
module fpu_dispatch
  import fpu_dispatch_pkg::*;
#(
  parameter int unsigned WIDTH   = FPU_32,
  parameter int unsigned DEPTH   = FPU_DISPATCH_DEPTH,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned TIMEOUT = FPU_DISPATCH_TIMEOUT
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  operation_e             req_op_i,
  input  logic [WIDTH-1:0]       req_a_i,
  input  logic [WIDTH-1:0]       req_b_i,
  input  logic [TAG_W-1:0]       req_tag_i,
  output logic                   fpu_start_o,
  output operation_e             fpu_op_o,
  output logic [WIDTH-1:0]       fpu_a_o,
  output logic [WIDTH-1:0]       fpu_b_o,
  input  logic                   fpu_busy_i,
  input  logic [WIDTH-1:0]       fpu_result_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [TAG_W-1:0]       rsp_tag_o,
  output logic [WIDTH-1:0]       rsp_result_o,
  output logic                   rsp_err_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned EntryW = fifo_entry_w(WIDTH, TAG_W);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_check
    $error("fpu_dispatch: DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT == 0) begin : gen_timeout_check
    $error("fpu_dispatch: TIMEOUT must be non-zero");
  end

  // Queue
  logic [EntryW-1:0] fifo_wdata, fifo_rdata;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [OpW-1:0]    head_op;
  logic [WIDTH-1:0]  head_a, head_b;
  logic [TAG_W-1:0]  head_tag;

  assign req_ready_o = !fifo_full;
  assign fifo_push   = req_valid_i && req_ready_o;
  assign fifo_wdata  = {req_op_i, req_a_i, req_b_i, req_tag_i};
  assign {head_op, head_a, head_b, head_tag} = fifo_rdata;

  fpu_req_fifo #(
    .Depth (DEPTH),
    .Width (EntryW)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (count_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Dispatch FSM
  dispatch_state_e  state_q, state_d;
  logic             fpu_start_q, fpu_start_d;
  operation_e       fpu_op_q, fpu_op_d;
  logic [WIDTH-1:0] fpu_a_q, fpu_a_d;
  logic [WIDTH-1:0] fpu_b_q, fpu_b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;

`ifdef FPU_DISPATCH_TIMEOUT_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    fpu_start_d  = 1'b0;
    fpu_op_d     = fpu_op_q;
    fpu_a_d      = fpu_a_q;
    fpu_b_d      = fpu_b_q;
    tag_d        = tag_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_result_d = rsp_result_q;
    fifo_pop     = 1'b0;
`ifdef FPU_DISPATCH_TIMEOUT_EN
    wdog_d       = wdog_q;
    rsp_err_d    = rsp_err_q;
`endif
    unique case (state_q)
      DIdle: begin
        if (!fifo_empty && !fpu_busy_i) begin
          fifo_pop    = 1'b1;
          fpu_op_d    = operation_e'(head_op);
          fpu_a_d     = head_a;
          fpu_b_d     = head_b;
          tag_d       = head_tag;
          fpu_start_d = 1'b1;
          state_d     = DIssue;
        end
      end
      // Busy here is the core reacting to our own start pulse, so it is not sampled.
      DIssue: begin
        state_d = DWait;
`ifdef FPU_DISPATCH_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      DWait: begin
        if (!fpu_busy_i) begin
          rsp_valid_d  = 1'b1;
          rsp_tag_d    = tag_q;
          rsp_result_d = fpu_result_i;
          state_d      = DResp;
`ifdef FPU_DISPATCH_TIMEOUT_EN
          rsp_err_d    = 1'b0;
        end else if (wdog_q == WdogW'(TIMEOUT - 1)) begin
          rsp_valid_d  = 1'b1;
          rsp_tag_d    = tag_q;
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          state_d      = DResp;
        end else begin
          wdog_d = wdog_q + WdogW'(1);
`endif
        end
      end
      DResp: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = DIdle;
        end
      end
      default: state_d = DIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= DIdle;
      fpu_start_q  <= 1'b0;
      fpu_op_q     <= OpAdd;
      fpu_a_q      <= '0;
      fpu_b_q      <= '0;
      tag_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      fpu_start_q  <= fpu_start_d;
      fpu_op_q     <= fpu_op_d;
      fpu_a_q      <= fpu_a_d;
      fpu_b_q      <= fpu_b_d;
      tag_q        <= tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_result_q <= rsp_result_d;
    end
  end

`ifdef FPU_DISPATCH_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err_o = rsp_err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  assign fpu_start_o  = fpu_start_q;
  assign fpu_op_o     = fpu_op_q;
  assign fpu_a_o      = fpu_a_q;
  assign fpu_b_o      = fpu_b_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_tag_o    = rsp_tag_q;
  assign rsp_result_o = rsp_result_q;

endmodule

// File: tb/tb_fpu_dispatch.sv
// Bench for fpu_dispatch: behavioural fpu_core stub plus a queue-based in-order reference model.
module tb_fpu_dispatch;
  import fpu_dispatch_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned TW = 5;
  localparam int unsigned TO = 64;

  logic              clk;
  logic              rst_ni;
  logic              req_valid_i, req_ready_o;
  operation_e        req_op_i;
  logic [W-1:0]      req_a_i, req_b_i;
  logic [TW-1:0]     req_tag_i;
  logic              fpu_start_o;
  operation_e        fpu_op_o;
  logic [W-1:0]      fpu_a_o, fpu_b_o;
  logic              fpu_busy_i;
  logic [W-1:0]      fpu_result_i;
  logic              rsp_valid_o, rsp_ready_i;
  logic [TW-1:0]     rsp_tag_o;
  logic [W-1:0]      rsp_result_o;
  logic              rsp_err_o;
  logic [$clog2(D):0] count_o;

  fpu_dispatch #(
    .WIDTH   (W),
    .DEPTH   (D),
    .TAG_W   (TW),
    .TIMEOUT (TO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_tag_i    (req_tag_i),
    .fpu_start_o  (fpu_start_o),
    .fpu_op_o     (fpu_op_o),
    .fpu_a_o      (fpu_a_o),
    .fpu_b_o      (fpu_b_o),
    .fpu_busy_i   (fpu_busy_i),
    .fpu_result_i (fpu_result_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_tag_o    (rsp_tag_o),
    .rsp_result_o (rsp_result_o),
    .rsp_err_o    (rsp_err_o),
    .count_o      (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-precision helpers (normal numbers only; operands are small integers).
  function automatic real sp2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:0] == 31'h0) return 0.0;
    e = int'(b[30:23]) - 127;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    for (int i = 0; i < e; i++) m = m * 2.0;
    for (int i = 0; i > e; i--) m = m / 2.0;
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    int          ex;
    if (r == 0.0) return 32'h0;
    d  = $realtobits(r);
    ex = int'(d[62:52]) - 896;
    return {d[63], ex[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_model(input operation_e op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      OpAdd:   return r2sp(sp2r(a) + sp2r(b));
      OpSub:   return r2sp(sp2r(a) - sp2r(b));
      OpMul:   return r2sp(sp2r(a) * sp2r(b));
      default: return 32'h7FC00000;
    endcase
  endfunction

  // fpu_core stub: busy from the edge after start, poisoned result until completion.
  logic        stuck;
  int unsigned lat_min, lat_max, lat_cnt;
  logic [W-1:0] pend_res;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      fpu_busy_i   <= 1'b0;
      fpu_result_i <= '0;
      lat_cnt      <= 0;
      pend_res     <= '0;
    end else if (fpu_start_o) begin
      fpu_busy_i   <= 1'b1;
      lat_cnt      <= $urandom_range(lat_max, lat_min);
      pend_res     <= fp_model(fpu_op_o, fpu_a_o, fpu_b_o);
      fpu_result_i <= 32'hDEADBEEF;
    end else if (fpu_busy_i && !stuck) begin
      if (lat_cnt <= 1) begin
        fpu_busy_i   <= 1'b0;
        fpu_result_i <= pend_res;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  // Reference model: expected responses in acceptance order; observed responses in handshake order.
  logic [TW-1:0] exp_tag_q [$];
  logic [W-1:0]  exp_res_q [$];
  logic          exp_err_q [$];
  logic [TW-1:0] got_tag_q [$];
  logic [W-1:0]  got_res_q [$];
  logic          got_err_q [$];

  int n_cmp, n_fail, n_start, n_stab;
  logic          stall_prev;
  logic [TW-1:0] stall_tag;
  logic [W-1:0]  stall_res;
  logic          stall_err;

  task automatic clear_queues();
    exp_tag_q.delete(); exp_res_q.delete(); exp_err_q.delete();
    got_tag_q.delete(); got_res_q.delete(); got_err_q.delete();
    n_start    = 0;
    n_stab     = 0;
    stall_prev = 1'b0;
  endtask

  // Called at a negedge with inputs already driven; records the handshakes of the next edge.
  task automatic tick();
    if (req_valid_i && req_ready_o) begin
      exp_tag_q.push_back(req_tag_i);
      exp_res_q.push_back(fp_model(req_op_i, req_a_i, req_b_i));
      exp_err_q.push_back(1'b0);
    end
    if (rsp_valid_o && rsp_ready_i) begin
      got_tag_q.push_back(rsp_tag_o);
      got_res_q.push_back(rsp_result_o);
      got_err_q.push_back(rsp_err_o);
    end
    if (stall_prev && (!rsp_valid_o || rsp_tag_o !== stall_tag || rsp_result_o !== stall_res
        || rsp_err_o !== stall_err)) n_stab++;
    stall_prev = rsp_valid_o && !rsp_ready_i;
    stall_tag  = rsp_tag_o;
    stall_res  = rsp_result_o;
    stall_err  = rsp_err_o;
    @(negedge clk);
    if (fpu_start_o) n_start++;
  endtask

  task automatic rand_req(input logic [TW-1:0] tag);
    req_op_i  = operation_e'(2'($urandom_range(2, 0)));
    req_a_i   = r2sp(real'($urandom_range(64, 1)));
    req_b_i   = r2sp(real'($urandom_range(64, 1)));
    req_tag_i = tag;
  endtask

  task automatic drain(input int n, output bit ok);
    req_valid_i = 1'b0;
    for (int i = 0; i < 3000 && got_tag_q.size() < n; i++) tick();
    ok = (got_tag_q.size() >= n);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (req_ready_o !== 1'b1 || count_o !== '0) begin
      n_fail++;
      $display("FAIL reset_queue: ready=%0b count=%0d, want ready=1 count=0", req_ready_o, count_o);
    end
    n_cmp++;
    if (fpu_start_o !== 1'b0 || rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: start=%0b rsp_valid=%0b err=%0b, want 0/0/0",
               fpu_start_o, rsp_valid_o, rsp_err_o);
    end
    n_cmp++;
    if (fpu_a_o !== '0 || fpu_b_o !== '0 || fpu_op_o !== OpAdd || rsp_tag_o !== '0
        || rsp_result_o !== '0) begin
      n_fail++;
      $display("FAIL reset_data: a=%h b=%h op=%0d tag=%0d res=%h, want all 0",
               fpu_a_o, fpu_b_o, fpu_op_o, rsp_tag_o, rsp_result_o);
    end
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%0b rsp_valid=%0b, want 1/0", req_ready_o, rsp_valid_o);
    end
  endtask

  task automatic test_add();
    bit ok;
    clear_queues();
    rsp_ready_i = 1'b1;
    req_op_i = OpAdd; req_a_i = 32'h3F800000; req_b_i = 32'h40000000; req_tag_i = 5'd3;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    n_cmp++;
    if (fpu_start_o !== 1'b0) begin
      n_fail++;
      $display("FAIL add_no_bypass: start=%0b one cycle after push, want 0", fpu_start_o);
    end
    tick();
    n_cmp++;
    if (fpu_start_o !== 1'b1 || fpu_a_o !== 32'h3F800000 || fpu_b_o !== 32'h40000000) begin
      n_fail++;
      $display("FAIL add_issue: start=%0b a=%h b=%h, want 1/3f800000/40000000",
               fpu_start_o, fpu_a_o, fpu_b_o);
    end
    drain(1, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL add_timeout: got %0d responses, want 1", got_tag_q.size());
    end else begin
      n_cmp++;
      if (got_res_q[0] !== 32'h40400000 || got_tag_q[0] !== 5'd3 || got_err_q[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL add_rsp: res=%h tag=%0d err=%0b, want 40400000/3/0",
                 got_res_q[0], got_tag_q[0], got_err_q[0]);
      end
    end
    n_cmp++;
    if (n_start != 1) begin
      n_fail++;
      $display("FAIL add_start_pulses: %0d, want 1", n_start);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_queues();
    rsp_ready_i = 1'b1;
    req_op_i = OpSub; req_a_i = 32'h40A00000; req_b_i = 32'h40400000; req_tag_i = 5'd1;
    req_valid_i = 1'b1;
    tick();
    req_op_i = OpMul; req_a_i = 32'h40000000; req_b_i = 32'h40400000; req_tag_i = 5'd2;
    tick();
    drain(2, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_timeout: got %0d responses, want 2", got_tag_q.size());
    end else begin
      n_cmp++;
      if (got_res_q[0] !== 32'h40000000 || got_tag_q[0] !== 5'd1) begin
        n_fail++;
        $display("FAIL b2b_sub: res=%h tag=%0d, want 40000000/1", got_res_q[0], got_tag_q[0]);
      end
      n_cmp++;
      if (got_res_q[1] !== 32'h40C00000 || got_tag_q[1] !== 5'd2) begin
        n_fail++;
        $display("FAIL b2b_mul: res=%h tag=%0d, want 40c00000/2", got_res_q[1], got_tag_q[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int accepted = 0;
    clear_queues();
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      rand_req(TW'(accepted));
      if (req_ready_o) accepted++;
      tick();
    end
    req_valid_i = 1'b0;
    n_cmp++;
    if (accepted != D + 1 || req_ready_o !== 1'b0 || count_o !== 3'(D)) begin
      n_fail++;
      $display("FAIL bp_full: accepted=%0d ready=%0b count=%0d, want %0d/0/%0d",
               accepted, req_ready_o, count_o, D + 1, D);
    end
    n_cmp++;
    if (rsp_valid_o !== 1'b1 || exp_tag_q.size() == 0 || rsp_tag_o !== exp_tag_q[0]
        || rsp_result_o !== exp_res_q[0]) begin
      n_fail++;
      $display("FAIL bp_head_rsp: valid=%0b tag=%0d res=%h, want head of request order",
               rsp_valid_o, rsp_tag_o, rsp_result_o);
    end
    n_cmp++;
    if (n_stab != 0) begin
      n_fail++;
      $display("FAIL bp_stable: %0d changes while stalled, want 0", n_stab);
    end
    rsp_ready_i = 1'b1;
    drain(accepted, ok);
    n_cmp++;
    if (!ok || got_tag_q.size() != exp_tag_q.size()) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d responses, want %0d", got_tag_q.size(), exp_tag_q.size());
    end
    for (int i = 0; i < got_tag_q.size() && i < exp_tag_q.size(); i++) begin
      n_cmp++;
      if (got_tag_q[i] !== exp_tag_q[i] || got_res_q[i] !== exp_res_q[i]) begin
        n_fail++;
        $display("FAIL bp_order[%0d]: tag=%0d res=%h, want tag=%0d res=%h",
                 i, got_tag_q[i], got_res_q[i], exp_tag_q[i], exp_res_q[i]);
      end
    end
  endtask

  task automatic test_count_hold();
    bit ok;
    int pushed = 0;
    clear_queues();
    rsp_ready_i = 1'b0;
    for (int c = 0; c < 20 && pushed < 4; c++) begin
      rand_req(TW'(pushed + 10));
      req_valid_i = 1'b1;
      if (req_ready_o) pushed++;
      tick();
    end
    req_valid_i = 1'b0;
    for (int c = 0; c < 50 && !rsp_valid_o; c++) tick();
    n_cmp++;
    if (rsp_valid_o !== 1'b1 || count_o !== 3'd3) begin
      n_fail++;
      $display("FAIL hold_setup: rsp_valid=%0b count=%0d, want 1/3", rsp_valid_o, count_o);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    rand_req(5'd20);
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    n_cmp++;
    if (count_o !== 3'd3 || fpu_start_o !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_push_pop: count=%0d start=%0b, want 3/1", count_o, fpu_start_o);
    end
    rsp_ready_i = 1'b1;
    drain(5, ok);
    n_cmp++;
    if (!ok || got_tag_q.size() != exp_tag_q.size()) begin
      n_fail++;
      $display("FAIL hold_drain: got %0d responses, want %0d", got_tag_q.size(), exp_tag_q.size());
    end
    for (int i = 0; i < got_tag_q.size() && i < exp_tag_q.size(); i++) begin
      n_cmp++;
      if (got_tag_q[i] !== exp_tag_q[i] || got_res_q[i] !== exp_res_q[i]) begin
        n_fail++;
        $display("FAIL hold_order[%0d]: tag=%0d res=%h, want tag=%0d res=%h",
                 i, got_tag_q[i], got_res_q[i], exp_tag_q[i], exp_res_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int sent = 0;
    clear_queues();
    lat_min = 1;
    lat_max = 6;
    for (int c = 0; c < 4000 && sent < 40; c++) begin
      rand_req(TW'($urandom));
      req_valid_i = ($urandom_range(9, 0) < 7);
      rsp_ready_i = $urandom_range(1, 0);
      if (req_valid_i && req_ready_o) sent++;
      tick();
    end
    rsp_ready_i = 1'b1;
    drain(sent, ok);
    lat_max = 4;
    n_cmp++;
    if (!ok || sent != 40 || got_tag_q.size() != exp_tag_q.size()) begin
      n_fail++;
      $display("FAIL rand_drain: sent=%0d got=%0d exp=%0d, want 40/40/40",
               sent, got_tag_q.size(), exp_tag_q.size());
    end
    for (int i = 0; i < got_tag_q.size() && i < exp_tag_q.size(); i++) begin
      n_cmp++;
      if (got_tag_q[i] !== exp_tag_q[i] || got_res_q[i] !== exp_res_q[i]
          || got_err_q[i] !== exp_err_q[i]) begin
        n_fail++;
        $display("FAIL rand_rsp[%0d]: tag=%0d res=%h err=%0b, want tag=%0d res=%h err=%0b",
                 i, got_tag_q[i], got_res_q[i], got_err_q[i],
                 exp_tag_q[i], exp_res_q[i], exp_err_q[i]);
      end
    end
    n_cmp++;
    if (n_start != sent || n_stab != 0) begin
      n_fail++;
      $display("FAIL rand_pulses: starts=%0d unstable=%0d, want %0d/0", n_start, n_stab, sent);
    end
  endtask

`ifdef FPU_DISPATCH_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int k = 0;
    clear_queues();
    stuck = 1'b1;
    rsp_ready_i = 1'b1;
    req_op_i = OpAdd; req_a_i = 32'h3F800000; req_b_i = 32'h3F800000; req_tag_i = 5'd7;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    for (int c = 0; c < 10 && !fpu_start_o; c++) tick();
    for (int c = 0; c < 200; c++) begin
      tick();
      k++;
      if (rsp_valid_o) break;
    end
    n_cmp++;
    if (k != TO + 1 || rsp_err_o !== 1'b1 || rsp_result_o !== '0 || rsp_tag_o !== 5'd7) begin
      n_fail++;
      $display("FAIL to_abort: cycles=%0d err=%0b res=%h tag=%0d, want %0d/1/0/7",
               k, rsp_err_o, rsp_result_o, rsp_tag_o, TO + 1);
    end
    rand_req(5'd8);
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    repeat (30) tick();
    n_cmp++;
    if (n_start != 1) begin
      n_fail++;
      $display("FAIL to_no_issue: starts=%0d while core busy, want 1", n_start);
    end
    stuck = 1'b0;
    drain(2, ok);
    n_cmp++;
    if (!ok || got_tag_q.size() != 2 || got_tag_q[1] !== exp_tag_q[1]
        || got_res_q[1] !== exp_res_q[1] || got_err_q[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL to_recover: got %0d responses, second tag=%0d err=%0b, want 2 with tag 8/0",
               got_tag_q.size(), got_tag_q.size() > 1 ? got_tag_q[1] : '0,
               got_err_q.size() > 1 ? got_err_q[1] : 1'b0);
    end
  endtask
`endif

  task automatic test_reset_in_wait();
    clear_queues();
    lat_min = 20;
    lat_max = 20;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_req(TW'(i + 24));
      req_valid_i = 1'b1;
      tick();
    end
    req_valid_i = 1'b0;
    for (int c = 0; c < 20 && n_start == 0; c++) tick();
    repeat (2) tick();
    n_cmp++;
    if (count_o !== 3'd2 || rsp_valid_o !== 1'b0 || fpu_a_o === '0) begin
      n_fail++;
      $display("FAIL rstw_setup: count=%0d rsp_valid=%0b a=%h, want 2/0/nonzero",
               count_o, rsp_valid_o, fpu_a_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (count_o !== '0 || fpu_start_o !== 1'b0 || rsp_valid_o !== 1'b0 || fpu_a_o !== '0
        || fpu_b_o !== '0 || fpu_op_o !== OpAdd || rsp_tag_o !== '0 || rsp_result_o !== '0) begin
      n_fail++;
      $display("FAIL rstw_async: count=%0d start=%0b valid=%0b a=%h b=%h, want all 0",
               count_o, fpu_start_o, rsp_valid_o, fpu_a_o, fpu_b_o);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    lat_min = 1;
    lat_max = 4;
    clear_queues();
    repeat (5) tick();
    n_cmp++;
    if (req_ready_o !== 1'b1 || count_o !== '0 || n_start != 0 || got_tag_q.size() != 0) begin
      n_fail++;
      $display("FAIL rstw_after: ready=%0b count=%0d starts=%0d rsps=%0d, want 1/0/0/0",
               req_ready_o, count_o, n_start, got_tag_q.size());
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    stuck       = 1'b0;
    lat_min     = 1;
    lat_max     = 4;
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_op_i    = OpAdd;
    req_a_i     = '0;
    req_b_i     = '0;
    req_tag_i   = '0;
    rsp_ready_i = 1'b0;
    clear_queues();
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_count_hold();
    test_random();
`ifdef FPU_DISPATCH_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_time_limit: simulation did not finish, want finish before 600000");
    $fatal(1, "time limit reached");
  end

endmodule
